// File: rtl/event_counter_bank.sv
// rtl/event_counter_bank.sv - multi-channel event counter bank with snapshot readout stream
//
// Counts qualifying events on NCH single-bit inputs into W-bit counters.
// SAT selects saturate (1) or wrap (0) on overflow; ovf flags are sticky
// until clr or rst. A snapshot of all counters is streamed out one channel
// per beat over a valid/ready handshake.
//
// Optional feature macro: EVENT_COUNTER_BANK_EDGE_EN
//   defined   : count rising edges of ev[i]
//   undefined : count every cycle ev[i] is high
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   en        global count enable
//   ev        per-channel event inputs
//   clr       synchronous clear of counters and ovf
//   rd_req    start snapshot readout (accepted only when idle)
//   rd_busy   readout in progress
//   rd_valid  rd_ch/rd_data hold a valid beat
//   rd_ready  consumer accepts current beat
//   rd_ch     channel index of current beat
//   rd_data   snapshot count of channel rd_ch
//   ovf       sticky per-channel overflow flags

module event_counter_bank #(
  parameter int NCH = 2,
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [NCH-1:0]                        ev,
  input  logic                                  clr,
  input  logic                                  rd_req,
  output logic                                  rd_busy,
  output logic                                  rd_valid,
  input  logic                                  rd_ready,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_ch,
  output logic [W-1:0]                          rd_data,
  output logic [NCH-1:0]                        ovf
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [W-1:0] MAXV = {W{1'b1}};
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [NCH-1:0] hit;
  logic [W-1:0]   cnt    [NCH];
  logic [W-1:0]   shadow [NCH];
  state_t         state_q, state_d;
  logic [CW-1:0]  idx_q;
  logic [CW-1:0]  idx_nxt;
  logic           load;
  logic           advance;
  logic           last;

`ifdef EVENT_COUNTER_BANK_EDGE_EN
  logic [NCH-1:0] prev;

  // Edge history tracks ev unconditionally so an event held across a
  // disabled or cleared cycle is not recounted once counting resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= ev;
    end
  end

  assign hit = ev & ~prev & {NCH{en}};
`else
  assign hit = ev & {NCH{en}};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          if (cnt[i] == MAXV) begin
            ovf[i] <= 1'b1;
            cnt[i] <= SAT ? MAXV : '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last    = (idx_q == LAST_IDX);
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    advance  = 1'b0;
    rd_busy  = 1'b0;
    rd_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        rd_busy  = 1'b1;
        rd_valid = 1'b1;
        if (rd_ready) begin
          advance = 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rd_data is a register of its own: it is loaded straight from the live
  // counter for beat 0 and from the shadow copy for later beats, so the
  // output never sits behind a combinational mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
      idx_q   <= '0;
      rd_data <= '0;
    end else if (load) begin
      for (int i = 0; i < NCH; i++) shadow[i] <= cnt[i];
      idx_q   <= '0;
      rd_data <= cnt[0];
    end else if (advance) begin
      if (last) begin
        idx_q   <= '0;
        rd_data <= '0;
      end else begin
        idx_q   <= idx_nxt;
        rd_data <= shadow[idx_nxt];
      end
    end
  end

  assign rd_ch = idx_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// tb/tb_event_counter_bank.sv - directed self-checking bench for event_counter_bank

module tb_event_counter_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr, rd_req, rd_ready;
  logic [1:0] ev;

  logic       busy_m, valid_m;
  logic [0:0] ch_m;
  logic [7:0] data_m;
  logic [1:0] ovf_m;

  logic       busy_s, valid_s;
  logic [0:0] ch_s;
  logic [3:0] data_s;
  logic [1:0] ovf_s;

  logic       busy_w, valid_w;
  logic [0:0] ch_w;
  logic [3:0] data_w;
  logic [1:0] ovf_w;

  int errors = 0;
  int checks = 0;

  logic [7:0] bt_m [2];
  logic [3:0] bt_s [2];
  logic [3:0] bt_w [2];
  logic [0:0] bt_ch [2];
  logic       bt_v [2];
  logic       bt_busy_after;

  event_counter_bank #(.NCH(2), .W(8), .SAT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .ev(ev), .clr(clr), .rd_req(rd_req),
    .rd_busy(busy_m), .rd_valid(valid_m), .rd_ready(rd_ready),
    .rd_ch(ch_m), .rd_data(data_m), .ovf(ovf_m)
  );

  event_counter_bank #(.NCH(2), .W(4), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .ev(ev), .clr(clr), .rd_req(rd_req),
    .rd_busy(busy_s), .rd_valid(valid_s), .rd_ready(rd_ready),
    .rd_ch(ch_s), .rd_data(data_s), .ovf(ovf_s)
  );

  event_counter_bank #(.NCH(2), .W(4), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .ev(ev), .clr(clr), .rd_req(rd_req),
    .rd_busy(busy_w), .rd_valid(valid_w), .rd_ready(rd_ready),
    .rd_ch(ch_w), .rd_data(data_w), .ovf(ovf_w)
  );

  task automatic pulse_events(input logic [1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      ev = mask;
      @(negedge clk);
      ev = 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic read_bank();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bt_m[b]  = data_m;
      bt_s[b]  = data_s;
      bt_w[b]  = data_w;
      bt_ch[b] = ch_m;
      bt_v[b]  = valid_m;
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    bt_busy_after = busy_m;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_ready = 1'b0; ev = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_m); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_m); end
    checks++; if (ch_m !== 1'b0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", ch_m); end
    checks++; if (data_m !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", data_m); end
    checks++; if (ovf_m !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b expected 00", ovf_m); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %0b expected 0", busy_m); end
  endtask

`ifdef EVENT_COUNTER_BANK_EDGE_EN
  task automatic test_edge();
    logic [5:0] seq;
    seq = 6'b101011;
    do_clr();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ev = {1'b0, seq[k]};
      @(negedge clk);
    end
    ev = 2'b00;
    @(negedge clk);
    en = 1'b0;
    ev = 2'b01;
    @(negedge clk);
    ev = 2'b00;
    @(negedge clk);
    read_bank();
    checks++; if (bt_m[0] !== 8'd3) begin errors++; $display("FAIL edge_ch0: got %0d expected 3", bt_m[0]); end
    checks++; if (bt_m[1] !== 8'd0) begin errors++; $display("FAIL edge_ch1: got %0d expected 0", bt_m[1]); end
  endtask
`else
  task automatic test_level();
    do_clr();
    en = 1'b1;
    ev = 2'b01;
    repeat (5) @(negedge clk);
    ev = 2'b00;
    en = 1'b0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL level_b0_valid: got %0b expected 1", valid_m); end
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL level_b0_busy: got %0b expected 1", busy_m); end
    checks++; if (ch_m !== 1'b0) begin errors++; $display("FAIL level_b0_ch: got %0d expected 0", ch_m); end
    checks++; if (data_m !== 8'd5) begin errors++; $display("FAIL level_b0_data: got %0d expected 5", data_m); end
    rd_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL level_b1_busy: got %0b expected 1", busy_m); end
    checks++; if (ch_m !== 1'b1) begin errors++; $display("FAIL level_b1_ch: got %0d expected 1", ch_m); end
    checks++; if (data_m !== 8'd0) begin errors++; $display("FAIL level_b1_data: got %0d expected 0", data_m); end
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL level_done_busy: got %0b expected 0", busy_m); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL level_done_valid: got %0b expected 0", valid_m); end

    // en gating: ch0 sees one enabled cycle, ch1 sees three plus one
    do_clr();
    en = 1'b1; ev = 2'b10;
    repeat (3) @(negedge clk);
    en = 1'b0; ev = 2'b11;
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0; ev = 2'b00;
    read_bank();
    checks++; if (bt_m[0] !== 8'd1) begin errors++; $display("FAIL en_gate_ch0: got %0d expected 1", bt_m[0]); end
    checks++; if (bt_m[1] !== 8'd4) begin errors++; $display("FAIL en_gate_ch1: got %0d expected 4", bt_m[1]); end
  endtask
`endif

  task automatic test_overflow();
    do_clr();
    en = 1'b1;
    pulse_events(2'b10, 17);
    en = 1'b0;
    checks++; if (ovf_m !== 2'b00) begin errors++; $display("FAIL ovf_w8: got %b expected 00", ovf_m); end
    checks++; if (ovf_s !== 2'b10) begin errors++; $display("FAIL ovf_sat: got %b expected 10", ovf_s); end
    checks++; if (ovf_w !== 2'b10) begin errors++; $display("FAIL ovf_wrap: got %b expected 10", ovf_w); end
    read_bank();
    checks++; if (bt_m[1] !== 8'd17) begin errors++; $display("FAIL ovf_w8_count: got %0d expected 17", bt_m[1]); end
    checks++; if (bt_s[1] !== 4'd15) begin errors++; $display("FAIL ovf_sat_count: got %0d expected 15", bt_s[1]); end
    checks++; if (bt_w[1] !== 4'd1) begin errors++; $display("FAIL ovf_wrap_count: got %0d expected 1", bt_w[1]); end
    checks++; if (bt_s[0] !== 4'd0) begin errors++; $display("FAIL ovf_sat_ch0: got %0d expected 0", bt_s[0]); end
    do_clr();
    checks++; if (ovf_s !== 2'b00) begin errors++; $display("FAIL clr_ovf_sat: got %b expected 00", ovf_s); end
    checks++; if (ovf_w !== 2'b00) begin errors++; $display("FAIL clr_ovf_wrap: got %b expected 00", ovf_w); end
    read_bank();
    checks++; if (bt_s[1] !== 4'd0) begin errors++; $display("FAIL clr_sat_count: got %0d expected 0", bt_s[1]); end
    checks++; if (bt_w[1] !== 4'd0) begin errors++; $display("FAIL clr_wrap_count: got %0d expected 0", bt_w[1]); end
  endtask

  task automatic test_backpressure();
    do_clr();
    en = 1'b1;
    pulse_events(2'b11, 7);
    pulse_events(2'b10, 2);
    en = 1'b0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    rd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (valid_m !== 1'b1 || ch_m !== 1'b0 || data_m !== 8'd7) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%0b ch=%0d data=%0d expected valid=1 ch=0 data=7", c, valid_m, ch_m, data_m);
      end
      if (c == 0) begin en = 1'b1; ev = 2'b11; end
      if (c == 1) clr = 1'b1;
      if (c == 2) begin clr = 1'b0; ev = 2'b01; end
      @(negedge clk);
    end
    checks++; if (ch_m !== 1'b0 || data_m !== 8'd7) begin
      errors++; $display("FAIL bp_hold_end: got ch=%0d data=%0d expected ch=0 data=7", ch_m, data_m);
    end
    ev = 2'b00; en = 1'b0; clr = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    checks++; if (valid_m !== 1'b1 || ch_m !== 1'b1 || data_m !== 8'd9) begin
      errors++; $display("FAIL bp_beat1: got valid=%0b ch=%0d data=%0d expected valid=1 ch=1 data=9", valid_m, ch_m, data_m);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL bp_done_valid: got %0b expected 0", valid_m); end
  endtask

  task automatic test_simultaneous();
    do_clr();
    en = 1'b1;
    pulse_events(2'b11, 2);
    pulse_events(2'b01, 2);
    en = 1'b0;
    rd_req = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    rd_ready = 1'b1;
    checks++; if (ch_m !== 1'b0 || data_m !== 8'd4) begin
      errors++; $display("FAIL sim_beat0: got ch=%0d data=%0d expected ch=0 data=4", ch_m, data_m);
    end
    @(negedge clk);
    rd_req = 1'b0;
    checks++; if (ch_m !== 1'b1 || data_m !== 8'd2) begin
      errors++; $display("FAIL sim_beat1: got ch=%0d data=%0d expected ch=1 data=2", ch_m, data_m);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (busy_m !== 1'b0 || valid_m !== 1'b0) begin
      errors++; $display("FAIL sim_req_ignored: got busy=%0b valid=%0b expected 0 0", busy_m, valid_m);
    end
    read_bank();
    checks++; if (bt_m[0] !== 8'd0 || bt_m[1] !== 8'd0) begin
      errors++; $display("FAIL sim_cleared: got (%0d,%0d) expected (0,0)", bt_m[0], bt_m[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_clr();
    en = 1'b1;
    pulse_events(2'b01, 3);
    pulse_events(2'b10, 1);
    en = 1'b0;
    read_bank();
    checks++; if (bt_m[0] !== 8'd3 || bt_m[1] !== 8'd1) begin
      errors++; $display("FAIL b2b_first_data: got (%0d,%0d) expected (3,1)", bt_m[0], bt_m[1]);
    end
    checks++; if (bt_ch[0] !== 1'b0 || bt_ch[1] !== 1'b1 || bt_v[0] !== 1'b1 || bt_v[1] !== 1'b1) begin
      errors++; $display("FAIL b2b_first_beats: got ch=(%0d,%0d) valid=(%0b,%0b) expected ch=(0,1) valid=(1,1)", bt_ch[0], bt_ch[1], bt_v[0], bt_v[1]);
    end
    checks++; if (bt_busy_after !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%0b expected 0", bt_busy_after); end
    read_bank();
    checks++; if (bt_m[0] !== 8'd3 || bt_m[1] !== 8'd1 || bt_v[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got (%0d,%0d) valid=%0b expected (3,1) valid=1", bt_m[0], bt_m[1], bt_v[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_clr();
    en = 1'b1;
    pulse_events(2'b11, 16);
    en = 1'b0;
    checks++; if (ovf_s !== 2'b11) begin errors++; $display("FAIL rstmid_pre_ovf: got %b expected 11", ovf_s); end
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    checks++; if (valid_m !== 1'b1 || ch_m !== 1'b1) begin
      errors++; $display("FAIL rstmid_beat1: got valid=%0b ch=%0d expected valid=1 ch=1", valid_m, ch_m);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got valid=%0b busy=%0b expected 0 0", valid_m, busy_m);
    end
    checks++; if (ovf_s !== 2'b00 || ch_m !== 1'b0 || data_m !== 8'd0) begin
      errors++; $display("FAIL rstmid_state: got ovf=%b ch=%0d data=%0d expected 00 0 0", ovf_s, ch_m, data_m);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_bank();
    checks++; if (bt_m[0] !== 8'd0 || bt_m[1] !== 8'd0 || bt_s[1] !== 4'd0) begin
      errors++; $display("FAIL rstmid_read: got (%0d,%0d) sat=%0d expected (0,0) sat=0", bt_m[0], bt_m[1], bt_s[1]);
    end
  endtask

  initial begin
    test_reset();
`ifdef EVENT_COUNTER_BANK_EDGE_EN
    test_edge();
`else
    test_level();
`endif
    test_overflow();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
